// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-stage types and constants.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {fault, pc, instr} entries between fetch and decode.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  fetch_entry_t           i_wdata,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_pop;

  // Pop on an empty FIFO is ignored.
  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The issue logic reserves a slot per outstanding request, so this never fires.
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_clear && (r_count == FULL_CNT)));

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction-fetch stage: single-outstanding req/gnt/rvalid fetch into a decode FIFO.
module instr_fetch #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  import rv32i_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_t r_state;
  logic [31:0]  r_pend_pc;
  logic         r_fault_sent;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;
  logic          w_idle;
  logic          w_space;
  logic          w_aligned;
  logic          w_fault_push;
  logic          w_resp_push;
  logic          w_push;
  logic          w_pop;

  assign w_idle    = (r_state == IDLE);
  assign w_space   = (w_count < FULL_CNT);
  assign w_aligned = (pc[1:0] == 2'b00);

  // Gated by rst so every output reads 0 while reset is held.
  assign imem_req  = !rst && w_idle && !flush && w_aligned && w_space;
  assign imem_addr = imem_req ? pc : '0;
  assign pc_en     = !rst && (flush || (imem_req && imem_gnt));

  // A misaligned pc is reported once; pc cannot move again until a redirect.
  assign w_fault_push = !rst && w_idle && !flush && !w_aligned && w_space && !r_fault_sent;
  assign w_resp_push  = (r_state == WAIT) && imem_rvalid && !flush;
  assign w_push       = w_fault_push || w_resp_push;
  assign w_pop        = if_valid && id_ready;

  always_comb begin
    w_wdata = '0;
    if (w_fault_push) begin
      w_wdata.fault = 1'b1;
      w_wdata.pc    = pc;
      w_wdata.instr = NOP_INSTR;
    end else begin
      w_wdata.fault = 1'b0;
      w_wdata.pc    = r_pend_pc;
      w_wdata.instr = imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pend_pc    <= '0;
      r_fault_sent <= 1'b0;
    end else begin
      if (flush) begin
        r_fault_sent <= 1'b0;
      end else if (w_fault_push) begin
        r_fault_sent <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (imem_req && imem_gnt) begin
            r_state   <= WAIT;
            r_pend_pc <= pc;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_state <= IDLE;
          end else if (flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // The stale response retires the drain even if another flush arrives with it.
          if (imem_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign if_valid = (w_count != '0);
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;
  assign if_fault = w_head.fault;

endmodule
